// File: rtl/xoshiro_pkg.sv
// Shared types, constants and the xoshiro128 step/scramble arithmetic used by
// both the free-running generator path and the jump sequencer.
package xoshiro_pkg;

  typedef enum logic [1:0] {
    MODE_PLUS         = 2'd0,
    MODE_PLUSPLUS     = 2'd1,
    MODE_STARSTAR     = 2'd2,
    MODE_PLUSPLUS_ALT = 2'd3
  } mode_e;

  // Word i of the state lives at index [i]: s[0] is s0.
  typedef logic [3:0][31:0] xs_state_t;

  localparam logic [31:0] DEFAULT_SEED0 = 32'h0D1929D2;
  localparam logic [31:0] DEFAULT_SEED1 = 32'h491DFB74;
  localparam logic [31:0] DEFAULT_SEED2 = 32'h473E5E7D;
  localparam logic [31:0] DEFAULT_SEED3 = 32'hD6CA8A07;

  // Index [0] holds the first constant word consumed by the sequencer.
  localparam logic [3:0][31:0] JUMP_C = {
    32'h77f2db5b, 32'h6fa035c3, 32'hf542d2d3, 32'h8764000b
  };
  localparam logic [3:0][31:0] LONG_JUMP_C = {
    32'h1c580662, 32'hccf5a0ef, 32'h0b6f099f, 32'hb523952e
  };

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] k);
    return (x << k) | (x >> (6'd32 - {1'b0, k}));
  endfunction

  function automatic xs_state_t xoshiro128_step(input xs_state_t s);
    xs_state_t   n;
    logic [31:0] t;
    t    = s[1] << 9;
    n    = s;
    n[2] = n[2] ^ n[0];
    n[3] = n[3] ^ n[1];
    n[1] = n[1] ^ n[2];
    n[0] = n[0] ^ n[3];
    n[2] = n[2] ^ t;
    n[3] = rotl32(n[3], 5'd11);
    return n;
  endfunction

  // Output function on the pre-step state; *5 and *9 are shift-add.
  function automatic logic [31:0] xoshiro128_scramble(input xs_state_t s, input mode_e mode);
    logic [31:0] sum;
    logic [31:0] x5;
    logic [31:0] r;
    logic [31:0] out;
    sum = s[0] + s[3];
    x5  = (s[1] << 2) + s[1];
    r   = rotl32(x5, 5'd7);
    case (mode)
      MODE_PLUS:     out = sum;
      MODE_STARSTAR: out = (r << 3) + r;
      default:       out = rotl32(sum, 5'd7) + s[0];
    endcase
    return out;
  endfunction

endpackage

// File: rtl/prng_fifo.sv
// Prefetch buffer between the generator and the CPU read path. The head word
// is held in its own register so the output never passes through the RAM read mux.
module prng_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign head  = head_q;

  always_comb begin
    do_pop   = pop && !flush && (count_q != '0);
    do_push  = push && !flush && ((count_q != FULL_COUNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end

    // Next head: incoming word when the buffer is (about to be) otherwise empty,
    // else the stored successor of the current head.
    head_d = head_q;
    if (count_d == '0) begin
      head_d = '0;
    end else if ((count_q == '0) || (do_pop && (count_q == (AW + 1)'(1)))) begin
      head_d = push_data;
    end else if (do_pop) begin
      head_d = mem_q[rd_ptr_q + 1'b1];
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/xoshiro128_engine.sv
// xoshiro128 engine: state registers, RUN/JUMP sequencer and scrambled output
// feeding a prefetch FIFO with valid/ready handshake.
module xoshiro128_engine
  import xoshiro_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] SEED0      = DEFAULT_SEED0,
  parameter logic [31:0] SEED1      = DEFAULT_SEED1,
  parameter logic [31:0] SEED2      = DEFAULT_SEED2,
  parameter logic [31:0] SEED3      = DEFAULT_SEED3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        write,
  input  logic [1:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic        jump_req,
  input  logic        jump_long,
  output logic        busy,
  output logic [31:0] rnd,
  output logic        rnd_valid,
  input  logic        rnd_ready
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_JUMP = 1'b1;

  logic        state_q, state_d;
  xs_state_t   s_q, s_d;
  xs_state_t   acc_q, acc_d;
  xs_state_t   acc_x;
  xs_state_t   s_stepped;
  logic [6:0]  cnt_q, cnt_d;
  logic        long_q, long_d;
  logic        busy_q, busy_d;
  logic [3:0][31:0] jump_c;
  logic        jump_bit;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] push_data;

  assign s_stepped = xoshiro128_step(s_q);
  assign jump_c    = long_q ? LONG_JUMP_C : JUMP_C;
  // Counter bits [6:5] pick the constant word, [4:0] the bit within it.
  assign jump_bit  = jump_c[cnt_q[6:5]][cnt_q[4:0]];

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    long_d     = long_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    fifo_pop   = 1'b0;
    push_data  = xoshiro128_scramble(s_q, mode_e'(mode));
    acc_x      = jump_bit ? (acc_q ^ s_q) : acc_q;

    if (state_q == ST_RUN) begin
      fifo_pop = rnd_ready;
      if (write) begin
        s_d[write_addr] = write_data;
        fifo_flush      = 1'b1;
      end else if (jump_req) begin
        fifo_flush = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
        long_d     = jump_long;
        state_d    = ST_JUMP;
      end else if (!fifo_full || rnd_ready) begin
        fifo_push = 1'b1;
        s_d       = s_stepped;
      end
    end else begin
      // The final iteration commits the accumulator, including its own XOR.
      acc_d = acc_x;
      s_d   = s_stepped;
      cnt_d = cnt_q + 7'd1;
      if (cnt_q == 7'd127) begin
        s_d     = acc_x;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
    end

    busy_d = (state_d == ST_JUMP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      s_q     <= {SEED3, SEED2, SEED1, SEED0};
      acc_q   <= '0;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
      busy_q  <= busy_d;
    end
  end

  prng_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (rnd)
  );

  assign busy      = busy_q;
  assign rnd_valid = !fifo_empty;

endmodule
